// File: rtl/adder_seq.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock, rippling the
// carry through a register, with a valid/ready handshake on both sides.
module adder_seq #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;

  // One CHUNK-wide slice of the captured operands plus the rippled carry.
  always_comb begin
    a_chunk   = a_reg[idx*CHUNK +: CHUNK];
    b_chunk   = b_reg[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            state     <= BUSY;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        BUSY: begin
          sum[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_reg               <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            cout      <= chunk_sum[CHUNK];
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result is held here until the consumer takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed corner cases, then a random
// handshake stream scored against a plain a+b+cin reference queue.
module tb_adder_seq;

  localparam int W = 128;
  localparam int C = 32;
  localparam int N = W / C;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  adder_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Mix of random, all-ones and zero chunks so carries often cross chunk edges.
  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    r[i*32 +: 32] = $urandom;
        2:       r[i*32 +: 32] = 32'hFFFF_FFFF;
        default: r[i*32 +: 32] = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  (W+1)'(in_ready),  (W+1)'(1));
    chk({tag, "_out_valid"}, (W+1)'(out_valid), (W+1)'(0));
    chk({tag, "_busy"},      (W+1)'(busy),      (W+1)'(0));
    chk({tag, "_result"},    {cout, sum},       '0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, (W+1)'(in_ready), (W+1)'(1));
  endtask

  // Runs one operation with out_ready high; optionally scrambles inputs mid-BUSY.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input bit scramble);
    logic [W:0] exp;
    int lat;
    exp       = ref_add(op_a, op_b, op_cin);
    out_ready = 1'b1;
    wait_ready(tag);
    a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_busy"}, (W+1)'(busy), (W+1)'(1));
    if (scramble) begin
      a = '1; b = '1; cin = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, (W+1)'(lat), (W+1)'(N));
    chk({tag, "_result"}, {cout, sum}, exp);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, (W+1)'({in_ready, out_valid}), (W+1)'(2'b10));
    $display("op %s: a=%0h b=%0h cin=%0d -> cout=%0d sum=%0h", tag, op_a, op_b, op_cin, exp[W],
             exp[W-1:0]);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   q[$];
    int accepted;
    int completed;
    int cyc;
    int n;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Accept on the very first edge after release, then the basic case.
    run_op("basic", W'(1), W'(2), 1'b0, 1'b0);
    run_op("all_ones", '1, '1, 1'b1, 1'b0);
    run_op("chunk_carry", W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0);
    run_op("mid_busy_change", W'(5), W'(7), 1'b0, 1'b1);

    // Backpressure: hold the result for 10 cycles while other operands are offered.
    out_ready = 1'b0;
    ra = rand_op(); rb = rand_op(); rc = 1'b1;
    exp = ref_add(ra, rb, rc);
    wait_ready("bp");
    a = ra; b = rb; cin = rc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", (W+1)'(out_valid), (W+1)'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = ~ra; b = ~rb; cin = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", (W+1)'({out_valid, in_ready, busy}), (W+1)'(3'b100));
      chk("bp_hold_result", {cout, sum}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", (W+1)'({out_valid, in_ready, busy}), (W+1)'(3'b010));
    chk("bp_result_kept", {cout, sum}, exp);
    $display("op bp: a=%0h b=%0h cin=1 -> cout=%0d sum=%0h", ra, rb, exp[W], exp[W-1:0]);

    // Reset during the second BUSY cycle abandons the operation.
    wait_ready("rst_mid");
    a = rand_op(); b = rand_op(); cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("rst_no_valid", (W+1)'(n), '0);
    run_op("after_reset", W'(10), W'(20), 1'b1, 1'b0);

    // Random stream with random in_valid / out_ready, scored in order.
    q = {};
    accepted = 0; completed = 0; cyc = 0;
    while ((accepted < 1000 || q.size() > 0) && cyc < 60000) begin
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q.push_back(ref_add(a, b, cin));
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", {cout, sum}, 'x);
        end else begin
          exp = q.pop_front();
          chk("rand_result", {cout, sum}, exp);
          $display("op rand %0d: cout=%0d sum=%0h", completed, cout, sum);
          completed++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_completed", (W+1)'(completed), (W+1)'(1000));
    chk("rand_queue_empty", (W+1)'(q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
